// File: rtl/hdlc_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : hdlc_rx_deframer
//  Function : HDLC receive front end. Hunts flags and aborts, removes stuffed
//             zeros, assembles LSB-first bytes and frames them.
//  Revision : 1.0
// ============================================================================
module hdlc_rx_deframer #(
    parameter int STUFF_RUN = 5,
    parameter int IDLE_ONES = 15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       Rx_Enable,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_EoF,
    output logic       Rx_FrameError,
    output logic       Rx_Idle
);
    localparam int                IDLE_W     = $clog2(IDLE_ONES + 1);
    localparam int                ONES_W     = $clog2(STUFF_RUN + 1);
    localparam logic [7:0]        FLAG_PAT   = 8'h7E;
    localparam logic [7:0]        ABORT_PAT  = 8'h7F;
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_ONES);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [ONES_W-1:0] RUN_MAX    = ONES_W'(STUFF_RUN);
    localparam logic [ONES_W-1:0] RUN_ONE    = ONES_W'(1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ARMED = 2'd1,
        FRAME = 2'd2
    } state_t;

    state_t            state_q;
    logic [7:0]        sreg_q;
    logic [7:0]        shift_q;
    logic [7:0]        data_q;
    logic [2:0]        bitcnt_q;
    logic [2:0]        skip_q;
    logic [ONES_W-1:0] ones_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              newbyte_q, flag_q, abort_q, valid_q, eof_q, ferr_q, exit_q;

    logic       flag_hit, abort_hit, out_bit, skipping, stuff_zero, keep, byte_done, idle_now;
    logic [7:0] shift_nx;

    assign flag_hit   = (sreg_q == FLAG_PAT);
    assign abort_hit  = (sreg_q == ABORT_PAT);
    assign out_bit    = sreg_q[7];
    // The bit leaving the window when a flag matches is the flag's own first bit.
    assign skipping   = flag_hit || (skip_q != 3'd0);
    assign stuff_zero = !out_bit && (ones_q == RUN_MAX);
    assign keep       = (state_q != HUNT) && !skipping && !abort_hit && !stuff_zero;
    assign byte_done  = keep && (bitcnt_q == 3'd7);
    assign shift_nx   = {out_bit, shift_q[7:1]};
    assign idle_now   = (idle_cnt_q == IDLE_MAX);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= HUNT;
            sreg_q     <= 8'hFF;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            bitcnt_q   <= 3'd0;
            skip_q     <= 3'd0;
            ones_q     <= '0;
            idle_cnt_q <= '0;
            newbyte_q  <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            valid_q    <= 1'b0;
            eof_q      <= 1'b0;
            ferr_q     <= 1'b0;
            exit_q     <= 1'b0;
        end else begin
            sreg_q    <= {sreg_q[6:0], Rx};
            newbyte_q <= 1'b0;
            flag_q    <= 1'b0;
            abort_q   <= 1'b0;
            ferr_q    <= 1'b0;
            exit_q    <= 1'b0;
            eof_q     <= 1'b0;
            if (!Rx_Enable) begin
                state_q    <= HUNT;
                skip_q     <= 3'd0;
                ones_q     <= '0;
                bitcnt_q   <= 3'd0;
                idle_cnt_q <= '0;
                valid_q    <= 1'b0;
            end else begin
                eof_q  <= exit_q;
                flag_q <= flag_hit;

                if (!Rx)
                    idle_cnt_q <= '0;
                else if (!idle_now)
                    idle_cnt_q <= idle_cnt_q + IDLE_ONE;

                if (flag_hit)
                    skip_q <= 3'd7;
                else if (skip_q != 3'd0)
                    skip_q <= skip_q - 3'd1;

                if (flag_hit)
                    ones_q <= '0;
                else if (!skipping && !abort_hit) begin
                    if (!out_bit)
                        ones_q <= '0;
                    else if (ones_q != RUN_MAX)
                        ones_q <= ones_q + RUN_ONE;
                end

                if (keep) begin
                    shift_q  <= shift_nx;
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
                if (byte_done) begin
                    data_q    <= shift_nx;
                    newbyte_q <= 1'b1;
                end

                case (state_q)
                    HUNT: begin
                        if (flag_hit)
                            state_q <= ARMED;
                    end
                    ARMED: begin
                        if (abort_hit || idle_now)
                            state_q <= HUNT;
                        else if (byte_done) begin
                            state_q <= FRAME;
                            valid_q <= 1'b1;
                        end
                    end
                    FRAME: begin
                        if (flag_hit) begin
                            ferr_q  <= (bitcnt_q != 3'd0);
                            valid_q <= 1'b0;
                            exit_q  <= 1'b1;
                            state_q <= ARMED;
                        end else if (abort_hit) begin
                            abort_q <= 1'b1;
                            valid_q <= 1'b0;
                            exit_q  <= 1'b1;
                            state_q <= HUNT;
                        end
                    end
                    default: state_q <= HUNT;
                endcase

                // Partial bytes never survive a flag, an abort or a return to hunting.
                if (flag_hit || abort_hit || (state_q == HUNT))
                    bitcnt_q <= 3'd0;
            end
        end
    end

    assign Rx_Data        = data_q;
    assign Rx_NewByte     = newbyte_q;
    assign Rx_FlagDetect  = flag_q;
    assign Rx_AbortDetect = abort_q;
    assign Rx_ValidFrame  = valid_q;
    assign Rx_EoF         = eof_q;
    assign Rx_FrameError  = ferr_q;
    assign Rx_Idle        = idle_now;

endmodule
`default_nettype wire
